// File: rtl/raycast_pkg.sv
// Shared constants, record layout and colour helpers for the raycaster
// column rasterizer.
package raycast_pkg;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;
  localparam int ROW_W         = 8;
  localparam int REC_W         = 38;

  localparam int HC_MSB = 37, HC_LSB = 29;
  localparam int LH_MSB = 28, LH_LSB = 21;
  localparam int WT_BIT = 20;
  localparam int MD_MSB = 19, MD_LSB = 16;
  localparam int WX_MSB = 15, WX_LSB = 0;

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  typedef struct packed {
    logic [8:0]  hcount;
    logic [7:0]  lineheight;
    logic        wall_type;
    logic [3:0]  mapdata;
    logic [15:0] wallx;
  } col_rec_t;

  // Entry 0 is the magenta "no texture" marker.
  localparam logic [15:0] PALETTE [16] = '{
    16'hF81F, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hFFFF, 16'h8410,
    16'hFD20, 16'h8000, 16'h0400, 16'h0010, 16'hC618, 16'h4208, 16'hA145, 16'h5AEB
  };

  function automatic logic [15:0] shade565(input logic [15:0] c);
    return (c >> 1) & 16'h7BEF;
  endfunction
endpackage

// File: rtl/column_pixel_shader.sv
// Combinational colour pick for one row of a column: ceiling, wall or floor.
module column_pixel_shader
  import raycast_pkg::*;
#(
  parameter logic [15:0] CEIL_COLOR  = 16'h2104,
  parameter logic [15:0] FLOOR_COLOR = 16'h6B4D,
  parameter logic [15:0] EDGE_COLOR  = 16'h0000
) (
  input  logic [ROW_W-1:0] i_row,
  input  logic [ROW_W-1:0] i_draw_start,
  input  logic [ROW_W-1:0] i_draw_end,
  input  col_rec_t         i_rec,
  output logic [15:0]      o_pixel
);
  logic [15:0] w_wall;
  logic        w_unused;

  assign w_unused = ^{i_rec.hcount, i_rec.lineheight, i_rec.wallx[10:0]};

  always_comb begin
    w_wall = PALETTE[i_rec.mapdata];
    if (i_rec.wall_type) w_wall = shade565(w_wall);
    if (i_row < i_draw_start)            o_pixel = CEIL_COLOR;
    else if (i_row > i_draw_end)         o_pixel = FLOOR_COLOR;
    else if (i_rec.wallx[15:11] == 5'd0) o_pixel = EDGE_COLOR;
    else                                 o_pixel = w_wall;
  end
endmodule

// File: rtl/column_rasterizer.sv
// Expands one DDA column record into SCREEN_HEIGHT frame-buffer writes,
// two register stages behind the accepting handshake.
module column_rasterizer
  import raycast_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 17,
  parameter logic [15:0] CEIL_COLOR  = 16'h2104,
  parameter logic [15:0] FLOOR_COLOR = 16'h6B4D,
  parameter logic [15:0] EDGE_COLOR  = 16'h0000
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  input  logic                  dda_fifo_tvalid_in,
  input  logic [REC_W-1:0]      dda_fifo_tdata_in,
  input  logic                  dda_fifo_tlast_in,
  output logic                  transformer_tready_out,
  output logic                  ray_valid_out,
  output logic [ADDR_WIDTH-1:0] ray_address_out,
  output logic [15:0]           ray_pixel_out,
  output logic                  ray_last_pixel_out
);
  state_t                r_state, w_state_nxt;
  logic                  r_run;
  col_rec_t              r_rec, w_in_rec;
  logic                  r_tlast;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_hs, w_tready, w_last_row, w_hc_ok;
  logic [ROW_W-1:0]      w_lh_c, w_start, w_end;

  logic                  r_s1_vld, r_s1_last;
  logic [ROW_W-1:0]      r_s1_row, r_s1_start, r_s1_end;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  col_rec_t              r_s1_rec;
  logic [15:0]           w_pixel;

  logic                  r_valid, r_last;
  logic [ADDR_WIDTH-1:0] r_addr_out;
  logic [15:0]           r_pixel;

  assign w_in_rec = '{hcount:     dda_fifo_tdata_in[HC_MSB:HC_LSB],
                      lineheight: dda_fifo_tdata_in[LH_MSB:LH_LSB],
                      wall_type:  dda_fifo_tdata_in[WT_BIT],
                      mapdata:    dda_fifo_tdata_in[MD_MSB:MD_LSB],
                      wallx:      dda_fifo_tdata_in[WX_MSB:WX_LSB]};

  assign w_last_row = (r_row == ROW_W'(SCREEN_HEIGHT - 1));
  assign w_hs       = dda_fifo_tvalid_in && w_tready;
  assign w_hc_ok    = (w_in_rec.hcount < 9'(SCREEN_WIDTH));

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tready = r_run;
        if (w_hs && w_hc_ok) w_state_nxt = DRAW;
      end
      DRAW: begin
        w_tready = w_last_row;
        if (w_last_row) w_state_nxt = (w_hs && w_hc_ok) ? DRAW : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_run holds tready low until the first edge after reset release.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_rec   <= '0;
      r_tlast <= 1'b0;
      r_row   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_hs) begin
        r_rec   <= w_in_rec;
        r_tlast <= dda_fifo_tlast_in;
        r_row   <= '0;
        r_addr  <= ADDR_WIDTH'(w_in_rec.hcount);
      end else if (r_state == DRAW) begin
        r_row  <= r_row + ROW_W'(1);
        r_addr <= r_addr + ADDR_WIDTH'(SCREEN_WIDTH);
      end
    end
  end

  // Zero height leaves end = start-1, so no row lands inside the span.
  assign w_lh_c  = (r_rec.lineheight > ROW_W'(SCREEN_HEIGHT)) ? ROW_W'(SCREEN_HEIGHT)
                                                               : r_rec.lineheight;
  assign w_start = ROW_W'(SCREEN_HEIGHT / 2) - (w_lh_c >> 1);
  assign w_end   = w_start + w_lh_c - ROW_W'(1);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_row   <= '0;
      r_s1_start <= '0;
      r_s1_end   <= '0;
      r_s1_addr  <= '0;
      r_s1_rec   <= '0;
    end else begin
      r_s1_vld  <= (r_state == DRAW);
      r_s1_last <= (r_state == DRAW) && r_tlast && w_last_row;
      if (r_state == DRAW) begin
        r_s1_row   <= r_row;
        r_s1_start <= w_start;
        r_s1_end   <= w_end;
        r_s1_addr  <= r_addr;
        r_s1_rec   <= r_rec;
      end
    end
  end

  column_pixel_shader #(
    .CEIL_COLOR (CEIL_COLOR),
    .FLOOR_COLOR(FLOOR_COLOR),
    .EDGE_COLOR (EDGE_COLOR)
  ) u_shader (
    .i_row       (r_s1_row),
    .i_draw_start(r_s1_start),
    .i_draw_end  (r_s1_end),
    .i_rec       (r_s1_rec),
    .o_pixel     (w_pixel)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_addr_out <= '0;
      r_pixel    <= '0;
    end else begin
      r_valid <= r_s1_vld;
      r_last  <= r_s1_vld && r_s1_last;
      if (r_s1_vld) begin
        r_addr_out <= r_s1_addr;
        r_pixel    <= w_pixel;
      end
    end
  end

  assign transformer_tready_out = w_tready;
  assign ray_valid_out          = r_valid;
  assign ray_address_out        = r_addr_out;
  assign ray_pixel_out          = r_pixel;
  assign ray_last_pixel_out     = r_last;
endmodule

// File: tb/tb_column_rasterizer.sv
// Directed plus randomized bench for column_rasterizer against a per-row
// arithmetic reference model.
module tb_column_rasterizer;
  logic        clk = 1'b0, rst = 1'b1, tvalid = 1'b0, tlast = 1'b0;
  logic [37:0] tdata = '0;
  logic        tready, vld, lastp;
  logic [16:0] addr;
  logic [15:0] pix;

  int errs = 0, checks = 0, n_strobe = 0, n_last = 0, last_addr = -1;
  int s0, l0;
  int          q_addr[$];
  logic [15:0] q_pix[$];
  bit          q_last[$];

  logic [15:0] pal [16] = '{
    16'hF81F, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hFFFF, 16'h8410,
    16'hFD20, 16'h8000, 16'h0400, 16'h0010, 16'hC618, 16'h4208, 16'hA145, 16'h5AEB
  };

  column_rasterizer dut (
    .pixel_clk_in          (clk),
    .rst_in                (rst),
    .dda_fifo_tvalid_in    (tvalid),
    .dda_fifo_tdata_in     (tdata),
    .dda_fifo_tlast_in     (tlast),
    .transformer_tready_out(tready),
    .ray_valid_out         (vld),
    .ray_address_out       (addr),
    .ray_pixel_out         (pix),
    .ray_last_pixel_out    (lastp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int row, input int lh, input bit wt,
                                          input int md, input logic [15:0] wx);
    int lc;
    int ds;
    int de;
    logic [15:0] c;
    lc = (lh > 240) ? 240 : lh;
    ds = 120 - lc / 2;
    de = ds + lc - 1;
    if (row < ds) return 16'h2104;
    if (row > de) return 16'h6B4D;
    if (wx[15:11] == 5'd0) return 16'h0000;
    c = pal[md];
    if (wt) c = {1'b0, c[15:1]} & 16'h7BEF;
    return c;
  endfunction

  task automatic model(input int hc, input int lh, input bit wt, input int md,
                       input logic [15:0] wx, input bit last);
    if (hc >= 320) return;
    for (int r = 0; r < 240; r++) begin
      q_addr.push_back(r * 320 + hc);
      q_pix.push_back(ref_pix(r, lh, wt, md, wx));
      q_last.push_back(last && (r == 239));
    end
  endtask

  always @(negedge clk) begin
    if (vld === 1'b1) begin
      n_strobe++;
      if (lastp === 1'b1) begin
        n_last++;
        last_addr = int'(addr);
      end
      if (q_addr.size() == 0) chk("strobe_with_record", 32'(q_addr.size() != 0), 1);
      else begin
        chk("pix_addr", addr, q_addr.pop_front());
        chk("pix_rgb", pix, q_pix.pop_front());
        chk("pix_last", lastp, q_last.pop_front());
      end
    end else begin
      chk("idle_last", lastp, 0);
    end
  end

  // Presents a record, waits (bounded) for the handshake edge, then books it.
  task automatic send(input int hc, input int lh, input bit wt, input int md,
                      input logic [15:0] wx, input bit last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = {hc[8:0], lh[7:0], wt, md[3:0], wx};
    tlast  = last;
    for (int k = 0; k < 600 && !ok; k++) begin
      if (tready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk("handshake", ok, 1);
    @(posedge clk);
    if (ok) model(hc, lh, wt, md, wx, last);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q_addr.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    chk("drain_empty", q_addr.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", vld, 0);
    chk("rst_addr", addr, 0);
    chk("rst_pix", pix, 0);
    chk("rst_last", lastp, 0);
    chk("rst_tready", tready, 0);
    rst = 1'b1;
    #1 chk("release_tready_wait", tready, 0);
    @(posedge clk);
    #1 chk("release_tready", tready, 1);

    // Basic column with latency probe
    s0 = n_strobe;
    send(5, 40, 0, 1, 16'hFFFF, 0);
    chk("lat_T0", vld, 0);
    @(posedge clk); #1 chk("lat_T1", vld, 0);
    @(posedge clk); #1 chk("lat_T2", vld, 1);
    chk("first_addr", addr, 5);
    drain();
    chk("t1_strobes", n_strobe - s0, 240);

    send(10, 255, 1, 2, 16'h8000, 0); drain();
    send(11, 0, 0, 3, 16'hFFFF, 0);   drain();
    send(12, 41, 0, 3, 16'h9000, 0);  drain();
    send(13, 60, 0, 4, 16'h07FF, 0);  drain();
    send(14, 80, 0, 0, 16'hFFFF, 0);  drain();

    // Back-to-back pair, second carries tlast
    s0 = n_strobe; l0 = n_last;
    @(negedge clk);
    tvalid = 1'b1; tdata = {9'd318, 8'd50, 1'b0, 4'd6, 16'hC000}; tlast = 1'b0;
    chk("b2b_idle_ready", tready, 1);
    @(posedge clk);
    model(318, 50, 0, 6, 16'hC000, 0);
    #1 tdata = {9'd319, 8'd200, 1'b1, 4'd7, 16'h4000}; tlast = 1'b1;
    for (int j = 0; j <= 481; j++) begin
      @(negedge clk);
      if (j < 480) chk("b2b_tready", tready, (j % 240) == 239);
      else chk("b2b_end_ready", tready, 1);
      if (j >= 2) chk("b2b_gapless", vld, 1);
      else chk("b2b_latency", vld, 0);
      if (j == 239) begin
        @(posedge clk);
        model(319, 200, 1, 7, 16'h4000, 1);
        #1 tvalid = 1'b0; tlast = 1'b0;
      end
    end
    drain();
    chk("b2b_strobes", n_strobe - s0, 480);
    chk("b2b_last_count", n_last - l0, 1);
    chk("b2b_last_addr", last_addr, 76799);

    // Out-of-range column is consumed silently
    s0 = n_strobe; l0 = n_last;
    send(400, 100, 0, 1, 16'hFFFF, 1);
    repeat (250) @(posedge clk);
    chk("drop_strobes", n_strobe - s0, 0);
    chk("drop_last", n_last - l0, 0);
    #1 chk("drop_ready", tready, 1);

    // Asynchronous reset in the middle of a column
    send(20, 100, 1, 5, 16'hA000, 0);
    repeat (59) @(posedge clk);
    #1 chk("row57_addr", addr, 57 * 320 + 20);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_pix", pix, 0);
    chk("mid_rst_last", lastp, 0);
    chk("mid_rst_tready", tready, 0);
    q_addr.delete(); q_pix.delete(); q_last.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    s0 = n_strobe; l0 = n_last;
    send(7, 30, 0, 9, 16'hF800, 1);
    drain();
    chk("post_rst_strobes", n_strobe - s0, 240);
    chk("post_rst_last", n_last - l0, 1);
    chk("post_rst_last_addr", last_addr, 239 * 320 + 7);

    // Randomized records, mixed gaps and back-to-back
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(0, 359), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 300)) @(posedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
